// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-byte holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity-error flag (perr).
module uart_rx #(
  parameter int CLK_PER_BIT = 217,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       perr,
`endif
  output logic       ferr
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'((CLK_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == BIT_LAST);

  // NOTE: synchronizer flops reset to 1 so the idle line is not mistaken for a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // NOTE: every sequential register uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = perr_q;
`endif

    if (ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d    = 1'b0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == BIT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          par_d   = rx_s_q;
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          // A same-cycle ack has already cleared valid_d, so overrun needs the raw flags.
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !ack) overrun_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          if (^{shift_q, par_q}) perr_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;
  assign ferr    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign perr    = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit; a frame-level model tracks
// the expected holding register and flags. Honors UART_RX_PARITY_EN when defined.
module tb_uart_rx;

  localparam int CPB   = 8;
  localparam int ACK_J = (CPB - 1) / 2 + 3;  // stop-bit cycle whose edge carries the sample

  logic       clk = 1'b0;
  logic       reset, rx, ack;
  logic [7:0] data;
  logic       valid, busy, overrun, ferr;
  logic       perr_obs;

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  logic perr;
  assign perr_obs = perr;
  uart_rx #(.CLK_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ack(ack), .data(data), .valid(valid),
    .busy(busy), .overrun(overrun), .perr(perr), .ferr(ferr));
`else
  assign perr_obs = 1'b0;
  uart_rx #(.CLK_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ack(ack), .data(data), .valid(valid),
    .busy(busy), .overrun(overrun), .ferr(ferr));
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference state.
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr, m_perr;

  // Observed status word: {data, valid, overrun, ferr, busy, perr}.
  function automatic logic [12:0] obs();
    return {data, valid, overrun, ferr, busy, perr_obs};
  endfunction

  function automatic logic [12:0] expected(input logic exp_busy);
    return {m_data, m_valid, m_ovr, m_ferr, exp_busy, m_perr};
  endfunction

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_ack();
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit,
                             input logic par_bit, input logic ack_same);
    logic was_valid;
    was_valid = m_valid && !ack_same;
    if (ack_same) model_ack();
    if (stop_bit) begin
      m_ovr   = m_ovr | was_valid;
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
`ifdef UART_RX_PARITY_EN
    if ((^b) != par_bit) m_perr = 1'b1;
`else
    if (par_bit === 1'bx) m_perr = m_perr;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) step();
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    model_ack();
  endtask

  // Drives one whole frame; v_before/v_after capture valid just before and after the stop sample.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                            input logic ack_at_stop, output logic v_before, output logic v_after);
    v_before = 1'b0;
    v_after  = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`endif
    rx = stop_bit;
    for (int j = 1; j <= CPB; j++) begin
      step();
      if (j == ACK_J) begin
        v_before = valid;
        ack      = ack_at_stop;
      end
      if (j == ACK_J + 1) begin
        ack     = 1'b0;
        v_after = valid;
      end
    end
    rx = 1'b1;
    model_frame(b, stop_bit, par_bit, ack_at_stop);
  endtask

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b1; rx = 1'b1; ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    got = obs();
    n_tests++;
    if (got !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", got, 13'h0);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_a5();
    logic vb, va;
    logic [12:0] got;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, vb, va);
    n_tests++;
    if (vb !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_valid_before_stop_sample: got %b expected 0", vb);
    end
    n_tests++;
    if (va !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_valid_after_stop_sample: got %b expected 1", va);
    end
    got = obs();
    n_tests++;
    if (got !== {8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL a5_status: got %h expected %h", got, {8'hA5, 5'b10000});
    end
    pulse_ack();
    got = obs();
    n_tests++;
    if (got !== {8'hA5, 5'b00000}) begin
      n_fail++;
      $display("FAIL a5_after_ack: got %h expected %h", got, {8'hA5, 5'b00000});
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    step();
    step();
    rx = 1'b1;
    step();
    step();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_during_start: got %b expected 1", busy);
    end
    repeat (4) step();
    n_tests++;
    if ({valid, ferr, busy, overrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL glitch_return_idle: got v/f/b/o=%b expected 0000", {valid, ferr, busy, overrun});
    end
    idle_cycles(CPB);
  endtask

  task automatic test_back_to_back();
    logic vb, va;
    logic [12:0] got;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, vb, va);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, vb, va);
    got = obs();
    n_tests++;
    if (got !== {8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %h expected %h", got, {8'hC3, 5'b11000});
    end
    pulse_ack();
    got = obs();
    n_tests++;
    if (got !== {8'hC3, 5'b00000}) begin
      n_fail++;
      $display("FAIL b2b_after_ack: got %h expected %h", got, {8'hC3, 5'b00000});
    end
  endtask

  task automatic test_framing_error();
    logic vb, va;
    logic [12:0] got;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    step();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, vb, va);
    idle_cycles(3 * CPB);
    got = obs();
    n_tests++;
    if (got !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ferr_stop_low: got %h expected %h", got, {8'h00, 5'b00100});
    end
  endtask

  // Runs with ferr still set from the previous test; ack coincident with a new byte.
  task automatic test_ack_collision();
    logic vb, va;
    logic [12:0] got;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, vb, va);
    got = obs();
    n_tests++;
    if (got !== {8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ferr_sticky_over_good_byte: got %h expected %h", got, {8'h81, 5'b10100});
    end
    send_frame(8'h7E, 1'b1, 1'b0, 1'b1, vb, va);
    got = obs();
    n_tests++;
    if (got !== {8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ack_collision_new_byte_wins: got %h expected %h", got, {8'h7E, 5'b10000});
    end
  endtask

  task automatic test_reset_midframe();
    logic vb, va;
    logic [12:0] got;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) step();
    reset = 1'b1;
    #1;
    got = obs();
    n_tests++;
    if (got !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_midframe_async: got %h expected %h", got, 13'h0);
    end
    step();
    reset = 1'b0;
    model_reset();
    idle_cycles(5 * CPB);
    send_frame(8'h12, 1'b1, ^8'h12, 1'b0, vb, va);
    got = obs();
    n_tests++;
    if (got !== {8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL frame_after_reset: got %h expected %h", got, {8'h12, 5'b10000});
    end
    pulse_ack();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic vb, va;
    logic [12:0] got;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, vb, va);
    got = obs();
    n_tests++;
    if (got !== {8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL parity_good: got %h expected %h", got, {8'h07, 5'b10000});
    end
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, vb, va);
    got = obs();
    n_tests++;
    if (got !== {8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL parity_bad: got %h expected %h", got, {8'h07, 5'b10001});
    end
    pulse_ack();
  endtask
`endif

  task automatic test_random();
    logic vb, va, stop_bit, par_bit, ack_stop;
    logic [7:0]  b;
    logic [12:0] got, exp;
    for (int n = 0; n < 40; n++) begin
      b        = 8'($urandom);
      stop_bit = ($urandom_range(0, 6) != 0);
      par_bit  = (^b) ^ ($urandom_range(0, 5) == 0);
      ack_stop = ($urandom_range(0, 5) == 0);
      send_frame(b, stop_bit, par_bit, ack_stop, vb, va);
      if (!stop_bit) idle_cycles(3 * CPB);
      got = obs();
      exp = expected(1'b0);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_frame_%0d (byte %h stop %b): got %h expected %h",
                 n, b, stop_bit, got, exp);
      end
      if ($urandom_range(0, 2) == 0) pulse_ack();
      idle_cycles($urandom_range(0, 2) * CPB);
    end
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_glitch();
    test_back_to_back();
    test_framing_error();
    test_ack_collision();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
